// File: rtl/vga_scan_out_if.sv
// Purpose: VRAM read bus between the display scan-out and the frame buffer.
// Signals:
//   VRAM_raddr - read address (word = one 12-bit pixel)
//   VRAM_dout  - read data {R[11:8],G[7:4],B[3:0]}, 1-clk latency RAM
// Modports: master = reader (scan-out), slave = RAM.
interface vga_scan_out_if;
  logic [31:0] VRAM_raddr;
  logic [11:0] VRAM_dout;

  modport master (output VRAM_raddr, input VRAM_dout);
  modport slave  (input VRAM_raddr, output VRAM_dout);
endinterface

// File: rtl/vga_scan_out.sv
// Purpose: VGA scan-out. Divides clk down to the pixel rate, runs the h/v
// raster counters, fetches one VRAM word per active pixel and drives
// registered RGB, active-low syncs and a per-frame marker.
// Ports:
//   clk, rst_n      - system clock, async active-low reset
//   vram            - VRAM read bus (master side)
//   vga_r/g/b       - 4-bit colour channels, black during blanking
//   hs_n, vs_n      - active-low horizontal / vertical sync
//   frame_start     - one-clk pulse on the pixel edge that ends a frame
module vga_scan_out #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vga_scan_out_if.master        vram,
  output logic [3:0]            vga_r,
  output logic [3:0]            vga_g,
  output logic [3:0]            vga_b,
  output logic                  hs_n,
  output logic                  vs_n,
  output logic                  frame_start
);

  localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_W        = $clog2(H_TOTAL);
  localparam int unsigned V_W        = $clog2(V_TOTAL);
  localparam int unsigned DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned H_SYNC_BEG = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_LST = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int unsigned V_SYNC_BEG = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_LST = V_ACTIVE + V_FP + V_SYNC - 1;

  logic [DIV_W-1:0] r_div_cnt;
  logic [H_W-1:0]   r_h_cnt;
  logic [V_W-1:0]   r_v_cnt;
  logic [31:0]      r_raddr;
  logic [11:0]      r_rgb;
  logic             r_hs_n;
  logic             r_vs_n;
  logic             r_frame_start;

  logic             w_pix_tick;
  logic             w_addr_edge;
  logic             w_h_last;
  logic             w_v_last;
  logic             w_active;
  logic             w_hsync;
  logic             w_vsync;
  logic [31:0]      w_pix_addr;

  // Raster decode for the pixel currently held in the counters.
  assign w_pix_tick  = (r_div_cnt == DIV_W'(CLK_DIV - 1));
  assign w_addr_edge = (r_div_cnt == '0);
  assign w_h_last    = (r_h_cnt == H_W'(H_TOTAL - 1));
  assign w_v_last    = (r_v_cnt == V_W'(V_TOTAL - 1));
  assign w_active    = (r_h_cnt < H_W'(H_ACTIVE)) && (r_v_cnt < V_W'(V_ACTIVE));
  assign w_hsync     = (r_h_cnt >= H_W'(H_SYNC_BEG)) && (r_h_cnt <= H_W'(H_SYNC_LST));
  assign w_vsync     = (r_v_cnt >= V_W'(V_SYNC_BEG)) && (r_v_cnt <= V_W'(V_SYNC_LST));
  assign w_pix_addr  = 32'(r_v_cnt) * 32'(H_ACTIVE) + 32'(r_h_cnt);

  // Pixel divider and raster counters; h/v only move on the pixel tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
    end else begin
      r_div_cnt <= w_pix_tick ? '0 : r_div_cnt + DIV_W'(1);
      if (w_pix_tick) begin
        if (w_h_last) begin
          r_h_cnt <= '0;
          r_v_cnt <= w_v_last ? '0 : r_v_cnt + V_W'(1);
        end else begin
          r_h_cnt <= r_h_cnt + H_W'(1);
        end
      end
    end
  end

  // Address issued at the start of the pixel period so the 1-clk RAM data
  // has settled well before the pixel tick samples it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raddr <= '0;
    end else if (w_addr_edge && w_active) begin
      r_raddr <= w_pix_addr;
    end
  end

  // Output stage: RGB and syncs share one register edge so they stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb         <= '0;
      r_hs_n        <= 1'b1;
      r_vs_n        <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_pix_tick && w_h_last && w_v_last;
      if (w_pix_tick) begin
        r_rgb  <= w_active ? vram.VRAM_dout : 12'h000;
        r_hs_n <= !w_hsync;
        r_vs_n <= !w_vsync;
      end
    end
  end

  assign vram.VRAM_raddr = r_raddr;
  assign vga_r           = r_rgb[11:8];
  assign vga_g           = r_rgb[7:4];
  assign vga_b           = r_rgb[3:0];
  assign hs_n            = r_hs_n;
  assign vs_n            = r_vs_n;
  assign frame_start     = r_frame_start;

endmodule
